// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared register-file writeback types and the default queue depth
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;
   localparam int WB_DEPTH = 4;
   // live clears when a younger pipeline write to the same register overtakes the entry
   typedef struct packed {
      logic     live;
      regbits_t wsel;
      word_t    wdat;
   } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: FIFO of long-latency writeback results with per-register kill and live-match lookup
//   CLK/RST         clock, synchronous active-high reset
//   push/push_entry enqueue at tail
//   pop             dequeue head (caller guarantees non-empty)
//   kill_en/sel     clear live bit of every entry targeting kill_sel
//   qsel/match      per-entry live hit on qsel
//   head/full/empty queue state
module rf_wb_fifo
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   input  logic             kill_en,
   input  regbits_t         kill_sel,
   input  regbits_t         qsel,
   output logic [DEPTH-1:0] match,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   wb_entry_t     q [DEPTH];
   logic [AW-1:0] hd, tl;
   logic [AW:0]   cnt;
   assign head  = q[hd];
   assign full  = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   // freed slots have their live bit cleared on pop, so live alone marks a real pending write
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) match[i] = q[i].live && q[i].wsel == qsel;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) q[i].live <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) if (kill_en && q[i].wsel == kill_sel) q[i].live <= 1'b0;
         if (pop) begin
            q[hd].live <= 1'b0;
            hd         <= hd + AW'(1);
         end
         // push lands after kill so a same-cycle entry keeps the liveness chosen by the caller
         if (push) begin
            q[tl] <= push_entry;
            tl    <= tl + AW'(1);
         end
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges pipeline and queued long-latency writebacks onto one register-file port
//   CLK/RST                       clock, synchronous active-high reset
//   pwb_wen/wsel/wdat             pipeline writeback (highest priority)
//   lwb_valid/wsel/wdat/ready     long-latency result handshake
//   qsel/qpending                 hazard query against live queued writes
//   WEN/wsel/wdat                 registered register-file write port
module rf_writeback_arbiter
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic     CLK,
   input  logic     RST,
   input  logic     pwb_wen,
   input  regbits_t pwb_wsel,
   input  word_t    pwb_wdat,
   input  logic     lwb_valid,
   input  regbits_t lwb_wsel,
   input  word_t    lwb_wdat,
   output logic     lwb_ready,
   input  regbits_t qsel,
   output logic     qpending,
   output logic     WEN,
   output regbits_t wsel,
   output word_t    wdat
);
   logic             pw, push, pop, full, empty;
   logic [DEPTH-1:0] match;
   wb_entry_t        head, in_entry;
   assign pw        = pwb_wen && pwb_wsel != '0;
   assign lwb_ready = !full && !RST;
   assign push      = lwb_valid && lwb_ready && lwb_wsel != '0;
   assign pop       = !RST && !pw && !empty;
   // a result arriving alongside a pipeline write to the same register is older, so it enters dead
   assign in_entry  = '{live: !(pw && pwb_wsel == lwb_wsel), wsel: lwb_wsel, wdat: lwb_wdat};
   assign qpending  = !RST && qsel != '0 && |match;
   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .push       (push),
      .push_entry (in_entry),
      .pop        (pop),
      .kill_en    (pw),
      .kill_sel   (pwb_wsel),
      .qsel       (qsel),
      .match      (match),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         WEN  <= 1'b0;
         wsel <= '0;
         wdat <= '0;
      end else if (pw) begin
         WEN  <= 1'b1;
         wsel <= pwb_wsel;
         wdat <= pwb_wdat;
      end else if (pop) begin
         WEN  <= head.live;
         wsel <= head.wsel;
         wdat <= head.wdat;
      end else begin
         WEN <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed table, corner sequences and random traffic against a queue model
module tb_rf_writeback_arbiter;
   localparam int DEPTH = 4;
   logic        CLK = 1'b0, RST = 1'b1;
   logic        pwb_wen = 1'b0, lwb_valid = 1'b0;
   logic [4:0]  pwb_wsel = '0, lwb_wsel = '0, qsel = '0;
   logic [31:0] pwb_wdat = '0, lwb_wdat = '0;
   logic        lwb_ready, qpending, WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   int checks = 0, errors = 0;

   rf_writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .pwb_wen(pwb_wen), .pwb_wsel(pwb_wsel), .pwb_wdat(pwb_wdat),
      .lwb_valid(lwb_valid), .lwb_wsel(lwb_wsel), .lwb_wdat(lwb_wdat), .lwb_ready(lwb_ready),
      .qsel(qsel), .qpending(qpending),
      .WEN(WEN), .wsel(wsel), .wdat(wdat)
   );

   always #5 CLK = ~CLK;

   typedef struct {bit live; bit [4:0] sel; bit [31:0] dat;} ment_t;
   ment_t       mq[$];
   bit          m_wen;
   bit [4:0]    m_ws;
   bit [31:0]   m_wd;

   typedef struct {
      bit rst, wen; bit [4:0] ws; bit [31:0] wd;
      bit lv; bit [4:0] ls; bit [31:0] ld; bit [4:0] qs;
      bit e_ready, e_qp, e_wen, e_chk; bit [4:0] e_ws; bit [31:0] e_wd;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit w, input bit [4:0] ws, input bit [31:0] wd,
                        input bit lv, input bit [4:0] ls, input bit [31:0] ld, input bit [4:0] qs);
      RST = r; pwb_wen = w; pwb_wsel = ws; pwb_wdat = wd;
      lwb_valid = lv; lwb_wsel = ls; lwb_wdat = ld; qsel = qs;
   endtask

   // one clock: check combinational outputs, advance the model, check registered outputs
   task automatic cycle();
      bit pw, acc, rdy, qp;
      ment_t h;
      #1;
      rdy = !RST && mq.size() < DEPTH;
      qp = 1'b0;
      if (!RST && qsel != 0) foreach (mq[i]) if (mq[i].live && mq[i].sel == qsel) qp = 1'b1;
      chk("lwb_ready", lwb_ready, rdy);
      chk("qpending", qpending, qp);
      if (RST) begin
         mq.delete(); m_wen = 0; m_ws = 0; m_wd = 0;
      end else begin
         pw  = pwb_wen && pwb_wsel != 0;
         acc = lwb_valid && rdy && lwb_wsel != 0;
         if (pw) begin
            foreach (mq[i]) if (mq[i].sel == pwb_wsel) mq[i].live = 0;
            m_wen = 1; m_ws = pwb_wsel; m_wd = pwb_wdat;
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_wen = h.live; m_ws = h.sel; m_wd = h.dat;
         end else m_wen = 0;
         if (acc) mq.push_back('{live: !(pw && pwb_wsel == lwb_wsel), sel: lwb_wsel, dat: lwb_wdat});
      end
      @(posedge CLK);
      #1;
      chk("WEN", WEN, m_wen);
      if (m_wen) begin
         chk("wsel", wsel, m_ws);
         chk("wdat", wdat, m_wd);
      end
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0,        1,5,32'h99,5, 0,0,0,1,0,0};
      tbl[1]  = '{1,0,0,0,        1,5,32'h99,5, 0,0,0,1,0,0};
      tbl[2]  = '{0,0,0,0,        1,5,32'h11,5, 1,0,0,1,0,0};
      tbl[3]  = '{0,1,3,32'hAA,   0,0,0,5,      1,1,1,1,3,32'hAA};
      tbl[4]  = '{0,0,0,0,        0,0,0,5,      1,1,1,1,5,32'h11};
      tbl[5]  = '{0,0,0,0,        0,0,0,5,      1,0,0,1,5,32'h11};
      tbl[6]  = '{0,0,0,0,        1,0,32'h77,0, 1,0,0,1,5,32'h11};
      tbl[7]  = '{0,0,0,0,        0,0,0,0,      1,0,0,1,5,32'h11};
      tbl[8]  = '{0,1,6,32'h4,    1,6,32'h3,6,  1,0,1,1,6,32'h4};
      tbl[9]  = '{0,0,0,0,        0,0,0,6,      1,0,0,0,0,0};
      tbl[10] = '{0,0,0,0,        0,0,0,6,      1,0,0,0,0,0};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].wen, tbl[i].ws, tbl[i].wd, tbl[i].lv, tbl[i].ls, tbl[i].ld, tbl[i].qs);
         #1;
         chk("tbl_ready", lwb_ready, tbl[i].e_ready);
         chk("tbl_qpending", qpending, tbl[i].e_qp);
         cycle();
         chk("tbl_wen", WEN, tbl[i].e_wen);
         if (tbl[i].e_chk) begin
            chk("tbl_wsel", wsel, tbl[i].e_ws);
            chk("tbl_wdat", wdat, tbl[i].e_wd);
         end
      end

      // fill the queue behind a stalled pipeline, then drain it in order
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 9, 32'h900 + i, 1, 5'(i), 32'h100 + i, 0);
         cycle();
      end
      chk("full_ready", lwb_ready, 0);
      drive(0, 1, 9, 32'h999, 1, 5, 32'h105, 0);
      cycle();
      cycle();
      chk("full_stall_ready", lwb_ready, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         chk("full_order_wen", WEN, 1);
         chk("full_order_sel", wsel, 5'(i));
         chk("full_order_dat", wdat, 32'h100 + i);
      end
      chk("full_ready_after", lwb_ready, 1);

      // kill a queued write with a younger pipeline write
      drive(0, 1, 9, 0, 1, 7, 32'h1, 0);
      cycle();
      drive(0, 1, 9, 0, 1, 8, 32'h2, 0);
      cycle();
      drive(0, 1, 7, 32'h5, 0, 0, 0, 7);
      cycle();
      chk("kill_pw_sel", wsel, 7);
      chk("kill_pw_dat", wdat, 32'h5);
      drive(0, 0, 0, 0, 0, 0, 0, 7);
      #1;
      chk("kill_qpending", qpending, 0);
      cycle();
      chk("kill_dead_wen", WEN, 0);
      cycle();
      chk("kill_r8_wen", WEN, 1);
      chk("kill_r8_sel", wsel, 8);
      chk("kill_r8_dat", wdat, 32'h2);
      cycle();

      // reset while the queue is draining
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 9, 0, 1, 5'(10 + i), 32'h200 + i, 0);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 11);
      cycle();
      chk("rst_drain_first", WEN, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 11);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 11);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_drain_wen", WEN, 0);
      end
      chk("rst_drain_ready", lwb_ready, 1);
      chk("rst_drain_qpending", qpending, 0);

      // random traffic on a small register set to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
